// File: rtl/gcd_requester_if.sv
// Bundle of the three handshakes around the GCD requester: the upstream
// operand stream, the engine operand/result protocol and the downstream
// result stream, plus the completed-result counter.
interface gcd_requester_if #(
    parameter int WIDTH = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic [WIDTH-1:0] gcd_a;
    logic [WIDTH-1:0] gcd_b;
    logic             operands_valid;
    logic             gcd_ready;
    logic             gcd_valid;
    logic [WIDTH-1:0] gcd_result;
    logic             ack;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [15:0]      done_count;

    // Requester side.
    modport slave (
        input  req_valid, req_a, req_b,
        input  gcd_ready, gcd_valid, gcd_result,
        input  res_ready,
        output req_ready,
        output gcd_a, gcd_b, operands_valid, ack,
        output res_valid, res_data, done_count
    );

    // Environment side: command source, engine and result sink.
    modport master (
        output req_valid, req_a, req_b,
        output gcd_ready, gcd_valid, gcd_result,
        output res_ready,
        input  req_ready,
        input  gcd_a, gcd_b, operands_valid, ack,
        input  res_valid, res_data, done_count
    );
endinterface

// File: rtl/gcd_requester.sv
// Initiator-side companion of the GCD engine. Operand pairs are queued in a
// small FIFO, issued one at a time to the engine, and each result is held in
// an output register until the downstream sink takes it.
module gcd_requester #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    gcd_requester_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ACK   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state_q, state_d;

    logic [WIDTH-1:0] mem_a_q [DEPTH];
    logic [WIDTH-1:0] mem_b_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;

    logic             ack_q, ack_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [15:0]      done_q, done_d;

    logic             push;
    logic             pop;
    logic             offer;
    logic             capture;

    // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of two.
    // req_ready is registered so it is low during reset and rises on the
    // first edge after release.
    always_comb begin
        push     = bus.req_valid && ready_q;
        pop      = offer && bus.gcd_ready;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        ready_d  = (cnt_d != FULL_CNT);
    end

    // Issue/capture sequencer: IDLE offers the head, WAIT captures the result
    // when the output register can take it, ACK pulses ack, DRAIN waits for
    // the engine to drop gcd_valid so a stale result is never taken twice.
    always_comb begin
        state_d = state_q;
        offer   = 1'b0;
        capture = 1'b0;
        ack_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                offer = (cnt_q != '0);
                if (offer && bus.gcd_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.gcd_valid && (!res_valid_q || bus.res_ready)) begin
                    capture = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                if (!bus.gcd_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register: a capture in the same cycle as a downstream take keeps
    // res_valid high with the new result.
    always_comb begin
        res_valid_d = res_valid_q;
        if (res_valid_q && bus.res_ready) begin
            res_valid_d = 1'b0;
        end
        if (capture) begin
            res_valid_d = 1'b1;
        end
        res_data_d = capture ? bus.gcd_result : res_data_q;
        done_d     = capture ? done_q + 16'd1 : done_q;
    end

    // Control and result state, cleared asynchronously while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            ack_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            done_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            ack_q       <= ack_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            done_q      <= done_d;
        end
    end

    // Operand storage; only the tail slot is written, so the head stays
    // stable while it is being offered.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= bus.req_a;
            mem_b_q[wr_ptr_q] <= bus.req_b;
        end
    end

    assign bus.req_ready      = ready_q;
    assign bus.gcd_a          = mem_a_q[rd_ptr_q];
    assign bus.gcd_b          = mem_b_q[rd_ptr_q];
    assign bus.operands_valid = offer;
    assign bus.ack            = ack_q;
    assign bus.res_valid      = res_valid_q;
    assign bus.res_data       = res_data_q;
    assign bus.done_count     = done_q;
endmodule

// File: doc/gcd_requester.md
Name: gcd_requester

Overview:
- Initiator-side companion to the team's GCD engine. It accepts operand pairs from an upstream valid/ready stream and buffers them in a small FIFO.
- It issues one pair at a time over the engine's operands_valid/ready/gcd_valid/ack protocol, captures each result, and presents it on a downstream valid/ready stream.
- It sits between a software-facing command path and the GCD engine, so the engine never sees back-to-back operand traffic it cannot absorb.

Parameters:
- WIDTH, 16, operand and result width in bits.
- DEPTH, 4, operand FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; all state is cleared while low.
- req_valid  input  1  upstream operand pair valid.
- req_ready  output  1  FIFO not full.
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B.
- gcd_a  output  WIDTH  operand A to engine; equals FIFO head.
- gcd_b  output  WIDTH  operand B to engine; equals FIFO head.
- operands_valid  output  1  pair offered to engine.
- gcd_ready  input  1  engine can accept operands.
- gcd_valid  input  1  engine result valid; held until ack.
- gcd_result  input  WIDTH  engine result.
- ack  output  1  result consumed; one-cycle pulse.
- res_valid  output  1  result register full.
- res_ready  input  1  downstream accepts result.
- res_data  output  WIDTH  captured GCD.
- done_count  output  16  results captured since reset; wraps 0xFFFF to 0.

Behaviour:
- Reset (reset low, async):
  - FIFO empties and the state machine goes to IDLE.
  - operands_valid=0, ack=0, res_valid=0, res_data=0, done_count=0.
  - req_ready=1 from the first edge after release.
- FIFO:
  - Push on req_valid & req_ready. Pop on operands_valid & gcd_ready.
  - Push and pop in the same cycle is legal; count is unchanged.
  - req_ready=0 when count==DEPTH. A push while full never happens.
  - Pointers wrap modulo DEPTH. Contents are held stable until popped.
- State machine:
  - IDLE: operands_valid=(count!=0); gcd_a/gcd_b show the head. On operands_valid & gcd_ready, pop and go to WAIT. gcd_a/gcd_b must not change while operands_valid=1 without a transfer.
  - WAIT: operands_valid=0. When gcd_valid & (!res_valid | res_ready):
    - res_data<=gcd_result, res_valid<=1, done_count++.
    - Go to ACK.
    - If res_valid=1 and res_ready=0, stay in WAIT; the engine holds its result.
  - ACK: ack=1 for exactly this cycle, registered and glitch-free. Go to DRAIN.
  - DRAIN: ack=0. Stay until gcd_valid==0, then go to IDLE. This prevents double-capturing a stale result.
- Output register:
  - res_valid clears on res_valid & res_ready unless a new capture happens in the same cycle; in that case it stays 1 with new data.
  - Latency: at most one pair in flight.
  - Minimum issue-to-capture is engine latency + 1 cycle.
  - Minimum gap between successive issues is 3 cycles (ACK, DRAIN, IDLE).
- Operand values: passed unmodified; zero operands are legal. Result is whatever the engine returns, e.g. (0,7)->7 and (0,0)->0.
- Reset mid-operation: an in-flight pair is dropped; no ack is issued. The engine is reset by the same system reset.
- gcd_valid asserted while in IDLE (protocol violation) is ignored: no capture, no ack.

Test Plan:
- Single pair (48,18); bench engine with 5-cycle latency -> operands_valid until transfer, ack pulse one cycle, res_data=6, res_valid=1, done_count=1.
- Push 5 pairs back-to-back with gcd_ready=0 -> req_ready falls after the 4th push; the 5th is held. Results 6, 5, 1, 7, 4 for (48,18),(25,15),(17,5),(49,14),(12,8) appear in order once gcd_ready=1.
- Backpressure: res_ready=0 with two pairs queued -> second result stays in WAIT, no second ack and no overwrite. Raising res_ready produces the second ack 1 cycle later with correct data.
- Simultaneous res_ready and capture cycle -> res_valid stays 1, res_data updates, no result lost; done_count increments once per result.
- Assert reset low mid-WAIT, async relative to clk -> outputs go to reset values immediately, FIFO empty, ack never pulses. After release, pair (9,6) returns 3.
- Zero operands (0,7) and (0,0) -> results 7 and 0. Stuck gcd_valid=1 after ack holds DRAIN, with no further issue until it drops.
